// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sipo_pkg.sv
// Shared types, reset values and sizing helpers for the falling-edge SIPO deserializer.
package gf180mcu_fd_sc_mcu9t5v0__sipo_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_e;

  function automatic int cnt_w(input int frame);
    return $clog2(frame + 1);
  endfunction

  localparam state_e RST_STATE = FILL;
  localparam logic   RST_Q_VLD = 1'b0;
  localparam logic   RST_PERR  = 1'b0;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sipo_shift.sv
// Falling-edge frame shift register; o_sr_next exposes the value the next edge will store.
module gf180mcu_fd_sc_mcu9t5v0__sipo_shift #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         CLKN,
  input  logic         RN,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_d,
  output logic [N-1:0] o_sr,
  output logic [N-1:0] o_sr_next
);

  logic [N-1:0] r_sr;
  logic [N-1:0] w_base;
  logic [N-1:0] w_shifted;

  assign w_base = i_clr ? '0 : r_sr;

  // MSB-first shifts left so the first bit ends on top; LSB-first shifts right so it ends at bit 0.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {w_base[N-2:0], i_d};
    end else begin : g_lsb
      assign w_shifted = {i_d, w_base[N-1:1]};
    end
  endgenerate

  assign o_sr_next = i_en ? w_shifted : w_base;
  assign o_sr      = r_sr;

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) begin
      r_sr <= '0;
    end else begin
      r_sr <= o_sr_next;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnrnq_sipo.sv
// Falling-edge serial-to-parallel deserializer with optional even parity and one-word output buffer.
module gf180mcu_fd_sc_mcu9t5v0__dffnrnq_sipo
  import gf180mcu_fd_sc_mcu9t5v0__sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             CLKN,
  input  logic             RN,
  input  logic             D,
  input  logic             D_VLD,
  output logic             D_RDY,
  input  logic             SYNC,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD,
  input  logic             Q_RDY,
  output logic             PERR
);

  localparam int FRAME = WIDTH + (PARITY_EN ? 1 : 0);
  localparam int CW    = cnt_w(FRAME);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);

  state_e           r_state;
  state_e           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_q;
  logic             r_q_vld;
  logic             r_perr;

  logic             w_en;
  logic             w_clr;
  logic             w_load;
  logic             w_out_free;
  logic [FRAME-1:0] w_sr;
  logic [FRAME-1:0] w_sr_next;
  logic [FRAME-1:0] w_src;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;

  gf180mcu_fd_sc_mcu9t5v0__sipo_shift #(
    .N         (FRAME),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .CLKN      (CLKN),
    .RN        (RN),
    .i_en      (w_en),
    .i_clr     (w_clr),
    .i_d       (D),
    .o_sr      (w_sr),
    .o_sr_next (w_sr_next)
  );

  // In FILL the word completes on this edge, so take it from the shifter's next value.
  assign w_src = (r_state == STALL) ? w_sr : w_sr_next;

  generate
    if (MSB_FIRST) begin : g_word_msb
      assign w_word = w_src[FRAME-1 -: WIDTH];
    end else begin : g_word_lsb
      assign w_word = w_src[WIDTH-1:0];
    end
    if (PARITY_EN) begin : g_par
      assign w_perr = ^w_src;
    end else begin : g_nopar
      assign w_perr = 1'b0;
    end
  endgenerate

  assign w_out_free = !r_q_vld || Q_RDY;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    if (r_state == FILL) begin
      w_en = D_VLD;
      if (SYNC) begin
        w_clr      = 1'b1;
        w_cnt_next = D_VLD ? CW'(1) : '0;
      end else if (D_VLD) begin
        if (r_cnt == CNT_LAST) begin
          if (w_out_free) begin
            w_load     = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_state_next = STALL;
            w_cnt_next   = CNT_FULL;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    end else begin
      if (Q_RDY) begin
        w_load       = 1'b1;
        w_cnt_next   = '0;
        w_state_next = FILL;
      end
    end
  end

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_q_vld <= RST_Q_VLD;
      r_perr  <= RST_PERR;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_q     <= w_word;
        r_perr  <= w_perr;
        r_q_vld <= 1'b1;
      end else if (Q_RDY) begin
        r_q_vld <= 1'b0;
      end
    end
  end

  assign D_RDY = (r_state == FILL);
  assign Q     = r_q;
  assign Q_VLD = r_q_vld;
  assign PERR  = r_perr;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnrnq_sipo.sv
// Directed bench: three instances cover LSB-first, parity and MSB-first configurations.
module tb_gf180mcu_fd_sc_mcu9t5v0__dffnrnq_sipo;

  logic       clkn;
  logic       rn;
  logic       d     [3];
  logic       vld   [3];
  logic       sync  [3];
  logic       qrdy  [3];
  logic       drdy  [3];
  logic       qvld  [3];
  logic       perr  [3];
  logic [7:0] q     [3];

  int n_vec;
  int n_err;

  gf180mcu_fd_sc_mcu9t5v0__dffnrnq_sipo #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
    .CLKN(clkn), .RN(rn), .D(d[0]), .D_VLD(vld[0]), .D_RDY(drdy[0]), .SYNC(sync[0]),
    .Q(q[0]), .Q_VLD(qvld[0]), .Q_RDY(qrdy[0]), .PERR(perr[0]));

  gf180mcu_fd_sc_mcu9t5v0__dffnrnq_sipo #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_par (
    .CLKN(clkn), .RN(rn), .D(d[1]), .D_VLD(vld[1]), .D_RDY(drdy[1]), .SYNC(sync[1]),
    .Q(q[1]), .Q_VLD(qvld[1]), .Q_RDY(qrdy[1]), .PERR(perr[1]));

  gf180mcu_fd_sc_mcu9t5v0__dffnrnq_sipo #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
    .CLKN(clkn), .RN(rn), .D(d[2]), .D_VLD(vld[2]), .D_RDY(drdy[2]), .SYNC(sync[2]),
    .Q(q[2]), .Q_VLD(qvld[2]), .Q_RDY(qrdy[2]), .PERR(perr[2]));

  initial clkn = 1'b1;
  always #5 clkn = ~clkn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clkn);
    #1;
  endtask

  task automatic send(input int k, input logic b);
    d[k]   = b;
    vld[k] = 1'b1;
    tick();
    vld[k] = 1'b0;
    d[k]   = 1'b0;
  endtask

  logic [7:0] w;

  initial begin
    n_vec = 0;
    n_err = 0;
    rn    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d[k] = 1'b0; vld[k] = 1'b0; sync[k] = 1'b0; qrdy[k] = 1'b0;
    end

    // Reset held with the clock running
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_q%0d", k), 32'(q[k]), 32'h00);
      check($sformatf("rst_qvld%0d", k), 32'(qvld[k]), 32'h0);
      check($sformatf("rst_perr%0d", k), 32'(perr[k]), 32'h0);
      check($sformatf("rst_drdy%0d", k), 32'(drdy[k]), 32'h1);
    end
    rn = 1'b1;
    tick();

    // LSB-first word 4D, consumed immediately
    qrdy[0] = 1'b1;
    w = 8'h4D;
    for (int i = 0; i < 7; i++) send(0, w[i]);
    check("w4d_qvld_before", 32'(qvld[0]), 32'h0);
    send(0, w[7]);
    check("w4d_q", 32'(q[0]), 32'h4D);
    check("w4d_qvld", 32'(qvld[0]), 32'h1);
    tick();
    check("w4d_qvld_one_edge", 32'(qvld[0]), 32'h0);
    check("w4d_q_kept", 32'(q[0]), 32'h4D);

    // Back-pressure: A5 then 3C with Q_RDY low
    qrdy[0] = 1'b0;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) send(0, w[i]);
    check("bp_a5_q", 32'(q[0]), 32'hA5);
    check("bp_a5_qvld", 32'(qvld[0]), 32'h1);
    check("bp_a5_drdy", 32'(drdy[0]), 32'h1);
    w = 8'h3C;
    for (int i = 0; i < 8; i++) send(0, w[i]);
    check("bp_stall_drdy", 32'(drdy[0]), 32'h0);
    check("bp_stall_q", 32'(q[0]), 32'hA5);
    tick();
    check("bp_hold_drdy", 32'(drdy[0]), 32'h0);
    check("bp_hold_q", 32'(q[0]), 32'hA5);
    check("bp_hold_qvld", 32'(qvld[0]), 32'h1);
    qrdy[0] = 1'b1;
    tick();
    check("bp_3c_q", 32'(q[0]), 32'h3C);
    check("bp_3c_qvld", 32'(qvld[0]), 32'h1);
    check("bp_3c_drdy", 32'(drdy[0]), 32'h1);
    tick();
    check("bp_drain_qvld", 32'(qvld[0]), 32'h0);

    // SYNC mid-frame: stale 3 bits must be discarded
    w = 8'hC3;
    for (int i = 0; i < 3; i++) send(0, 1'b1);
    sync[0] = 1'b1;
    send(0, w[0]);
    sync[0] = 1'b0;
    for (int i = 1; i < 7; i++) begin
      send(0, w[i]);
      check($sformatf("sync_noword_%0d", i), 32'(qvld[0]), 32'h0);
    end
    send(0, w[7]);
    check("sync_q", 32'(q[0]), 32'hC3);
    check("sync_qvld", 32'(qvld[0]), 32'h1);
    tick();

    // SYNC on the completing edge wins; that beat starts a new frame
    for (int i = 0; i < 7; i++) send(0, 1'b1);
    w = 8'h96;
    sync[0] = 1'b1;
    send(0, w[0]);
    sync[0] = 1'b0;
    check("sync_last_noword", 32'(qvld[0]), 32'h0);
    for (int i = 1; i < 8; i++) send(0, w[i]);
    check("sync_last_q", 32'(q[0]), 32'h96);
    check("sync_last_qvld", 32'(qvld[0]), 32'h1);
    tick();

    // Parity: FF+0 good, FE+0 bad
    qrdy[1] = 1'b1;
    w = 8'hFF;
    for (int i = 0; i < 8; i++) send(1, w[i]);
    check("par_ff_noword_yet", 32'(qvld[1]), 32'h0);
    send(1, 1'b0);
    check("par_ff_q", 32'(q[1]), 32'hFF);
    check("par_ff_perr", 32'(perr[1]), 32'h0);
    check("par_ff_qvld", 32'(qvld[1]), 32'h1);
    w = 8'hFE;
    for (int i = 0; i < 8; i++) send(1, w[i]);
    send(1, 1'b0);
    check("par_fe_q", 32'(q[1]), 32'hFE);
    check("par_fe_perr", 32'(perr[1]), 32'h1);
    check("par_fe_qvld", 32'(qvld[1]), 32'h1);

    // MSB-first, back-to-back then gapped
    qrdy[2] = 1'b1;
    w = 8'h81;
    for (int i = 0; i < 8; i++) send(2, w[7-i]);
    check("msb_81_q", 32'(q[2]), 32'h81);
    w = 8'h01;
    for (int i = 0; i < 8; i++) send(2, w[7-i]);
    check("msb_01_q", 32'(q[2]), 32'h01);
    check("msb_01_perr", 32'(perr[2]), 32'h0);
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin send(2, w[7-i]); tick(); end
    check("msb_gap_81_q", 32'(q[2]), 32'h81);
    w = 8'h01;
    for (int i = 0; i < 7; i++) begin send(2, w[7-i]); tick(); end
    send(2, w[0]);
    check("msb_gap_01_q", 32'(q[2]), 32'h01);
    check("msb_gap_01_qvld", 32'(qvld[2]), 32'h1);

    // Asynchronous reset mid-frame with a word pending
    qrdy[0] = 1'b0;
    w = 8'h12;
    for (int i = 0; i < 8; i++) send(0, w[i]);
    check("ar_pending_qvld", 32'(qvld[0]), 32'h1);
    for (int i = 0; i < 3; i++) send(0, 1'b1);
    #1 rn = 1'b0;
    #1;
    check("ar_qvld", 32'(qvld[0]), 32'h0);
    check("ar_q", 32'(q[0]), 32'h00);
    check("ar_drdy", 32'(drdy[0]), 32'h1);
    rn = 1'b1;
    qrdy[0] = 1'b1;
    w = 8'h0F;
    for (int i = 0; i < 5; i++) send(0, w[i]);
    check("ar_partial_dropped", 32'(qvld[0]), 32'h0);
    for (int i = 5; i < 8; i++) send(0, w[i]);
    check("ar_0f_q", 32'(q[0]), 32'h0F);
    check("ar_0f_qvld", 32'(qvld[0]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
